tinyml_seq: RTL and testbench

Top-level sequencer for the TinyML accelerator datapath. On `start` it runs one matrix pass: it streams n weight words from the unified buffer into the weighting buffer, streams m input rows into the systolic data setup, waits a fixed drain interval for the MMU and partial-sum pipeline, then writes m result words back to the unified buffer and pulses `done`. It owns the unified-buffer address/write-enable port and the per-stage strobes; it does not touch data.

---
 rtl/tinyml_pkg.sv | 25 ++
 rtl/tinyml_cnt.sv | 42 ++++
 rtl/tinyml_seq.sv | 204 ++++++++++++++++++++
 tb/tb_tinyml_seq.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinyml_pkg.sv
// -----------------------------------------------------------------------------
// tinyml_pkg
// Shared definitions for the TinyML accelerator sequencer:
//   - seq_state_e        : pass sequencer state encoding
//   - TINYML_WORD_SIZE   : unified-buffer word / address width
//   - DEF_W/I/O_BASE     : default region base addresses (per-instance overridable)
// -----------------------------------------------------------------------------
package tinyml_pkg;

    localparam int TINYML_WORD_SIZE = 16;

    localparam logic [TINYML_WORD_SIZE-1:0] DEF_W_BASE = 16'h0000;
    localparam logic [TINYML_WORD_SIZE-1:0] DEF_I_BASE = 16'h0100;
    localparam logic [TINYML_WORD_SIZE-1:0] DEF_O_BASE = 16'h0200;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_FEED   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5
    } seq_state_e;

endpackage

// File: rtl/tinyml_cnt.sv
// -----------------------------------------------------------------------------
// tinyml_cnt
// Loadable up-counter with terminal-count flag.
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-low reset (count -> 0)
//   load_i       load load_val_i (has priority over en_i)
//   load_val_i   value loaded on load_i
//   en_i         increment by one
//   tc_val_i     terminal value to compare against
//   count_o      current count
//   tc_o         count_o == tc_val_i
// -----------------------------------------------------------------------------
module tinyml_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] tc_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == tc_val_i);

endmodule

// File: rtl/tinyml_seq.sv
// -----------------------------------------------------------------------------
// tinyml_seq
// Top-level sequencer for one TinyML matrix pass: load n weight words, feed m
// input rows, wait DRAIN_CYC cycles, write m results back, pulse done.
// Drives only the unified-buffer address/write-enable and per-stage strobes.
// Ports:
//   clk       clock, rising edge
//   reset     asynchronous active-low reset
//   start     begin a pass (sampled only in IDLE)
//   m, n      row/result count and weight count, latched on accepted start
//   busy      high in every state except IDLE
//   done      one-cycle end-of-pass pulse
//   uni_wen   unified-buffer write enable
//   uni_addr  unified-buffer address
//   w_load    weighting buffer captures read data (LOAD_W delayed 1 cycle)
//   d_valid   data setup captures read data (FEED delayed 1 cycle)
//   acc_clr   clear partial-sum accumulators (first FEED cycle)
//   res_rd    pop one result (every WRITE cycle)
// -----------------------------------------------------------------------------
module tinyml_seq
    import tinyml_pkg::*;
#(
    parameter int                    WORD_SIZE = TINYML_WORD_SIZE,
    parameter int                    ARRAY_DIM = 8,
    parameter int                    DRAIN_CYC = 16,
    parameter logic [WORD_SIZE-1:0]  W_BASE    = WORD_SIZE'(DEF_W_BASE),
    parameter logic [WORD_SIZE-1:0]  I_BASE    = WORD_SIZE'(DEF_I_BASE),
    parameter logic [WORD_SIZE-1:0]  O_BASE    = WORD_SIZE'(DEF_O_BASE)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [4:0]           m,
    input  logic [4:0]           n,
    output logic                 busy,
    output logic                 done,
    output logic                 uni_wen,
    output logic [WORD_SIZE-1:0] uni_addr,
    output logic                 w_load,
    output logic                 d_valid,
    output logic                 acc_clr,
    output logic                 res_rd
);

    // The counter is loaded with 1 on entry to each phase (the entry edge
    // already emits index 0), so a zero drain length could never terminate.
    if (DRAIN_CYC < 1 || ARRAY_DIM < 1) begin : g_param_check
        $error("tinyml_seq: DRAIN_CYC and ARRAY_DIM must be >= 1");
    end

    localparam logic [WORD_SIZE-1:0] DRAIN_TC = WORD_SIZE'(DRAIN_CYC);
    localparam logic [WORD_SIZE-1:0] CNT_ONE  = WORD_SIZE'(1);

    seq_state_e           state_q;
    logic [4:0]           m_q;
    logic [4:0]           n_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 uni_wen_q;
    logic [WORD_SIZE-1:0] uni_addr_q;
    logic                 w_load_q;
    logic                 d_valid_q;
    logic                 acc_clr_q;
    logic                 res_rd_q;

    // Shared counter: holds the index of the NEXT address to emit within the
    // current phase, and doubles as the drain cycle count.
    logic                 cnt_load_d;
    logic                 cnt_en_d;
    logic [WORD_SIZE-1:0] cnt_tc_val_d;
    logic [WORD_SIZE-1:0] cnt_val;
    logic                 cnt_tc;

    always_comb begin
        cnt_tc_val_d = WORD_SIZE'(m_q);
        case (state_q)
            ST_LOAD_W: cnt_tc_val_d = WORD_SIZE'(n_q);
            ST_DRAIN:  cnt_tc_val_d = DRAIN_TC;
            default:   cnt_tc_val_d = WORD_SIZE'(m_q);
        endcase
    end

    assign cnt_load_d = ((state_q == ST_IDLE) && start) ||
                        (((state_q == ST_LOAD_W) || (state_q == ST_FEED) ||
                          (state_q == ST_DRAIN)) && cnt_tc);
    assign cnt_en_d   = (state_q == ST_LOAD_W) || (state_q == ST_FEED) ||
                        (state_q == ST_DRAIN)  || (state_q == ST_WRITE);

    tinyml_cnt #(
        .WIDTH (WORD_SIZE)
    ) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load_d),
        .load_val_i (CNT_ONE),
        .en_i       (cnt_en_d),
        .tc_val_i   (cnt_tc_val_d),
        .count_o    (cnt_val),
        .tc_o       (cnt_tc)
    );

    // Outputs are registered and reflect the state being entered, so the
    // address for index k appears in the same cycle the state shows it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            m_q        <= '0;
            n_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            uni_wen_q  <= 1'b0;
            uni_addr_q <= '0;
            w_load_q   <= 1'b0;
            d_valid_q  <= 1'b0;
            acc_clr_q  <= 1'b0;
            res_rd_q   <= 1'b0;
        end else begin
            // One-cycle read latency: capture strobes trail the address phase.
            w_load_q  <= (state_q == ST_LOAD_W);
            d_valid_q <= (state_q == ST_FEED);
            acc_clr_q <= 1'b0;
            done_q    <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        m_q    <= m;
                        n_q    <= n;
                        busy_q <= 1'b1;
                        if (m == 5'd0 || n == 5'd0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= ST_LOAD_W;
                            uni_addr_q <= W_BASE;
                        end
                    end
                end

                ST_LOAD_W: begin
                    if (cnt_tc) begin
                        state_q    <= ST_FEED;
                        uni_addr_q <= I_BASE;
                        acc_clr_q  <= 1'b1;
                    end else begin
                        uni_addr_q <= W_BASE + cnt_val;
                    end
                end

                ST_FEED: begin
                    if (cnt_tc) begin
                        state_q <= ST_DRAIN;  // address held through drain
                    end else begin
                        uni_addr_q <= I_BASE + cnt_val;
                    end
                end

                ST_DRAIN: begin
                    if (cnt_tc) begin
                        state_q    <= ST_WRITE;
                        uni_addr_q <= O_BASE;
                        uni_wen_q  <= 1'b1;
                        res_rd_q   <= 1'b1;
                    end
                end

                ST_WRITE: begin
                    if (cnt_tc) begin
                        state_q    <= ST_DONE;
                        uni_addr_q <= '0;
                        uni_wen_q  <= 1'b0;
                        res_rd_q   <= 1'b0;
                        done_q     <= 1'b1;
                    end else begin
                        uni_addr_q <= O_BASE + cnt_val;
                    end
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q    <= ST_IDLE;
                    busy_q     <= 1'b0;
                    uni_wen_q  <= 1'b0;
                    res_rd_q   <= 1'b0;
                    uni_addr_q <= '0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign uni_wen  = uni_wen_q;
    assign uni_addr = uni_addr_q;
    assign w_load   = w_load_q;
    assign d_valid  = d_valid_q;
    assign acc_clr  = acc_clr_q;
    assign res_rd   = res_rd_q;

endmodule

// File: tb/tb_tinyml_seq.sv
// -----------------------------------------------------------------------------
// tb_tinyml_seq
// Table-driven check of tinyml_seq (DRAIN_CYC=4) plus hand-written sequences
// for address wrap, asynchronous reset mid-pass and a full-size 31x31 pass.
// A second instance with W_BASE=16'hFFFF shares the stimulus.
// -----------------------------------------------------------------------------
module tb_tinyml_seq;

    localparam int DC = 4;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  m     = 5'd0;
    logic [4:0]  n     = 5'd0;

    logic        busy, done, uni_wen, w_load, d_valid, acc_clr, res_rd;
    logic [15:0] uni_addr;
    logic        busy_w, done_w, uni_wen_w, w_load_w, d_valid_w, acc_clr_w, res_rd_w;
    logic [15:0] uni_addr_w;

    always #5 clk = ~clk;

    tinyml_seq #(.DRAIN_CYC(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .m(m), .n(n),
        .busy(busy), .done(done), .uni_wen(uni_wen), .uni_addr(uni_addr),
        .w_load(w_load), .d_valid(d_valid), .acc_clr(acc_clr), .res_rd(res_rd)
    );

    tinyml_seq #(.DRAIN_CYC(DC), .W_BASE(16'hFFFF)) dut_w (
        .clk(clk), .reset(reset), .start(start), .m(m), .n(n),
        .busy(busy_w), .done(done_w), .uni_wen(uni_wen_w), .uni_addr(uni_addr_w),
        .w_load(w_load_w), .d_valid(d_valid_w), .acc_clr(acc_clr_w), .res_rd(res_rd_w)
    );

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        wen;
        logic [15:0] addr;
        logic        wl;
        logic        dv;
        logic        ac;
        logic        rd;
    } out_t;

    typedef struct {
        logic       start;
        logic [4:0] m;
        logic [4:0] n;
        out_t       exp;
    } vec_t;

    int   tests = 0;
    int   fails = 0;
    vec_t vecs[$];

    function automatic out_t o(input logic b, input logic d, input logic w,
                               input logic [15:0] a, input logic wl,
                               input logic dv, input logic ac, input logic rd);
        out_t r;
        r = {b, d, w, a, wl, dv, ac, rd};
        return r;
    endfunction

    function automatic void add(input logic s, input logic [4:0] mm,
                                input logic [4:0] nn, input out_t e);
        vec_t v;
        v.start = s;
        v.m     = mm;
        v.n     = nn;
        v.exp   = e;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input out_t e);
        out_t a;
        a = {busy, done, uni_wen, uni_addr, w_load, d_valid, acc_clr, res_rd};
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got busy=%b done=%b wen=%b addr=%h wl=%b dv=%b clr=%b rd=%b, want busy=%b done=%b wen=%b addr=%h wl=%b dv=%b clr=%b rd=%b",
                     name, a.busy, a.done, a.wen, a.addr, a.wl, a.dv, a.ac, a.rd,
                     e.busy, e.done, e.wen, e.addr, e.wl, e.dv, e.ac, e.rd);
        end
    endtask

    task automatic check_addr_w(input string name, input logic [15:0] e);
        tests++;
        if (uni_addr_w !== e) begin
            fails++;
            $display("FAIL %s: got uni_addr=%h, want %h", name, uni_addr_w, e);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int c;
        c = 0;
        while (busy && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        tests++;
        if (busy) begin
            fails++;
            $display("FAIL %s: still busy after %0d cycles, want idle", name, budget);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_cnt, wr_cnt, rd_cnt, wl_cnt, dv_cnt, addr_err;
        int done_cnt, done_j, acc_j, busy_fall_j;
        logic busy_prev;
        out_t z;
        z = o(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

        // ---- pass m=3, n=2 --------------------------------------------------
        add(1, 5'd3, 5'd2, o(1,0,0,16'd0,  0,0,0,0));
        add(0, 5'd3, 5'd2, o(1,0,0,16'd1,  1,0,0,0));
        add(0, 5'd3, 5'd2, o(1,0,0,16'd256,1,0,1,0));
        add(0, 5'd3, 5'd2, o(1,0,0,16'd257,0,1,0,0));
        add(0, 5'd3, 5'd2, o(1,0,0,16'd258,0,1,0,0));
        add(0, 5'd3, 5'd2, o(1,0,0,16'd258,0,1,0,0));
        add(0, 5'd3, 5'd2, o(1,0,0,16'd258,0,0,0,0));
        add(0, 5'd3, 5'd2, o(1,0,0,16'd258,0,0,0,0));
        add(0, 5'd3, 5'd2, o(1,0,0,16'd258,0,0,0,0));
        add(0, 5'd3, 5'd2, o(1,0,1,16'd512,0,0,0,1));
        add(0, 5'd3, 5'd2, o(1,0,1,16'd513,0,0,0,1));
        add(0, 5'd3, 5'd2, o(1,0,1,16'd514,0,0,0,1));
        add(0, 5'd3, 5'd2, o(1,1,0,16'd0,  0,0,0,0));
        add(0, 5'd3, 5'd2, o(0,0,0,16'd0,  0,0,0,0));
        // ---- degenerate passes ----------------------------------------------
        add(1, 5'd0, 5'd5, o(1,1,0,16'd0,0,0,0,0));
        add(0, 5'd0, 5'd5, o(0,0,0,16'd0,0,0,0,0));
        add(1, 5'd3, 5'd0, o(1,1,0,16'd0,0,0,0,0));
        add(0, 5'd3, 5'd0, o(0,0,0,16'd0,0,0,0,0));
        // ---- start held, m/n toggled mid-pass, m=1 n=1 -----------------------
        add(1, 5'd1, 5'd1, o(1,0,0,16'd0,  0,0,0,0));
        add(1, 5'd5, 5'd6, o(1,0,0,16'd256,1,0,1,0));
        add(1, 5'd7, 5'd2, o(1,0,0,16'd256,0,1,0,0));
        add(1, 5'd0, 5'd0, o(1,0,0,16'd256,0,0,0,0));
        add(1, 5'd9, 5'd3, o(1,0,0,16'd256,0,0,0,0));
        add(1, 5'd2, 5'd8, o(1,0,0,16'd256,0,0,0,0));
        add(1, 5'd4, 5'd4, o(1,0,1,16'd512,0,0,0,1));
        add(1, 5'd6, 5'd1, o(1,1,0,16'd0,  0,0,0,0));
        add(1, 5'd1, 5'd1, o(0,0,0,16'd0,  0,0,0,0));
        add(1, 5'd1, 5'd1, o(1,0,0,16'd0,  0,0,0,0));
        add(0, 5'd1, 5'd1, o(1,0,0,16'd256,1,0,1,0));
        add(0, 5'd1, 5'd1, o(1,0,0,16'd256,0,1,0,0));
        add(0, 5'd1, 5'd1, o(1,0,0,16'd256,0,0,0,0));
        add(0, 5'd1, 5'd1, o(1,0,0,16'd256,0,0,0,0));
        add(0, 5'd1, 5'd1, o(1,0,0,16'd256,0,0,0,0));
        add(0, 5'd1, 5'd1, o(1,0,1,16'd512,0,0,0,1));
        add(0, 5'd1, 5'd1, o(1,1,0,16'd0,  0,0,0,0));
        add(0, 5'd1, 5'd1, o(0,0,0,16'd0,  0,0,0,0));

        // ---- reset state ----------------------------------------------------
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", z);
        check_addr_w("reset_state_w", 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("idle_after_release", z);

        // ---- table-driven vectors ---------------------------------------------
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            start = vecs[i].start;
            m     = vecs[i].m;
            n     = vecs[i].n;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // ---- W_BASE=FFFF wraps to 0000 ----------------------------------------
        @(negedge clk);
        start = 1'b1; m = 5'd1; n = 5'd2;
        @(posedge clk); #1;
        check_addr_w("wrap_k0", 16'hFFFF);
        start = 1'b0;
        @(posedge clk); #1;
        check_addr_w("wrap_k1", 16'h0000);
        wait_idle("wrap_pass_end", 30);

        // ---- asynchronous reset during FEED, m=4 ------------------------------
        @(negedge clk);
        start = 1'b1; m = 5'd4; n = 5'd1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("feed_before_reset", o(1,0,0,16'd257,0,1,0,0));
        #2;
        reset = 1'b0;
        #1;
        check("reset_immediate", z);
        check_addr_w("reset_immediate_w", 16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check($sformatf("post_reset%0d", c), z);
        end

        // ---- full-size pass m=31, n=31 ----------------------------------------
        acc_cnt = 0; wr_cnt = 0; rd_cnt = 0; wl_cnt = 0; dv_cnt = 0;
        addr_err = 0; done_cnt = 0; done_j = -1; acc_j = -1; busy_fall_j = -1;
        busy_prev = 1'b0;
        @(negedge clk);
        start = 1'b1; m = 5'd31; n = 5'd31;
        for (int j = 0; j < 130; j++) begin
            @(posedge clk); #1;
            if (j == 0) start = 1'b0;
            if (acc_clr) begin
                acc_cnt++;
                if (acc_j < 0) acc_j = j;
            end
            if (uni_wen) begin
                if (uni_addr !== 16'(512 + wr_cnt)) addr_err++;
                wr_cnt++;
            end
            if (res_rd)  rd_cnt++;
            if (w_load)  wl_cnt++;
            if (d_valid) dv_cnt++;
            if (done) begin
                done_cnt++;
                if (done_j < 0) done_j = j;
            end
            if (busy_prev && !busy && busy_fall_j < 0) busy_fall_j = j;
            busy_prev = busy;
        end
        check_int("big_acc_clr_pulses", acc_cnt, 1);
        check_int("big_acc_clr_cycle", acc_j, 31);
        check_int("big_writes", wr_cnt, 31);
        check_int("big_write_addr_errors", addr_err, 0);
        check_int("big_res_rd", rd_cnt, 31);
        check_int("big_w_load", wl_cnt, 31);
        check_int("big_d_valid", dv_cnt, 31);
        check_int("big_done_pulses", done_cnt, 1);
        check_int("big_done_cycle", done_j, 31 + 2 * 31 + DC);
        check_int("big_busy_fall_cycle", busy_fall_j, 31 + 2 * 31 + DC + 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
